// File: rtl/axi_lat_ram.sv
// AXI4 slave memory model with configurable read latency, INCR/FIXED bursts and byte strobes.
// Optional LFSR stall injection on wready/rvalid is enabled by defining AXI_LAT_RAM_STALL_INJECT_EN.
module axi_lat_ram #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 25,
  parameter int          ID_WIDTH     = 8,
  parameter int          MEM_SIZE_LG  = 16,
  parameter int          READ_LATENCY = 4,
  parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
  input  logic                      aclk,
  input  logic                      resetn,
  input  logic [ID_WIDTH-1:0]       s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ID_WIDTH-1:0]       s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [ID_WIDTH-1:0]       s_axi_rid,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int DEPTH  = 1 << MEM_SIZE_LG;
  localparam int CNT_W  = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

  typedef logic [MEM_SIZE_LG-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t   w_state;
  idx_t       w_idx;
  logic [7:0] w_len;
  logic [7:0] w_beat;
  logic       w_fixed;
  logic       w_fire;

  r_state_t   r_state;
  idx_t       r_idx;
  idx_t       r_idx_next;
  logic [7:0] r_len;
  logic [7:0] r_beat;
  logic       r_fixed;
  logic [CNT_W-1:0] r_cnt;

  idx_t aw_idx;
  idx_t ar_idx;
  logic w_hold;
  logic r_hold;
  logic unused_inputs;

  assign aw_idx      = s_axi_awaddr[MEM_SIZE_LG+OFF-1:OFF];
  assign ar_idx      = s_axi_araddr[MEM_SIZE_LG+OFF-1:OFF];
  assign r_idx_next  = r_fixed ? r_idx : r_idx + idx_t'(1);
  assign w_fire      = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready;
  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;

  // Size, wlast and the sub-word/upper address bits carry no meaning in this aligned model.
  assign unused_inputs = ^{s_axi_awsize, s_axi_arsize, s_axi_wlast, s_axi_awaddr, s_axi_araddr};

`ifdef AXI_LAT_RAM_STALL_INJECT_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) lfsr <= STALL_SEED;
    else         lfsr <= lfsr_next;
  end

  // wready/rvalid are registered, so the decision is taken from the LFSR value of the coming cycle.
  assign w_hold = lfsr_next[0];
  assign r_hold = lfsr_next[1];
`else
  assign w_hold = 1'b0;
  assign r_hold = 1'b0;
`endif

  // NOTE: the storage array is deliberately kept out of reset so that contents survive resetn.
  always_ff @(posedge aclk) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      w_idx         <= '0;
      w_len         <= '0;
      w_beat        <= '0;
      w_fixed       <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= !w_hold;
            s_axi_bid     <= s_axi_awid;
            w_idx         <= aw_idx;
            w_len         <= s_axi_awlen;
            w_beat        <= '0;
            w_fixed       <= (s_axi_awburst == 2'b00);
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          // Beat count alone ends the burst; wlast is not consulted.
          if (w_fire && (w_beat == w_len)) begin
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
            w_state      <= W_RESP;
          end else begin
            s_axi_wready <= !w_hold;
            if (w_fire) begin
              w_beat <= w_beat + 8'd1;
              if (!w_fixed) w_idx <= w_idx + idx_t'(1);
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: all state uses non-blocking assignments, so a word registered into rdata in the same
  // cycle it is written returns its old contents (read-before-write).
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_fixed       <= 1'b0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rid     <= s_axi_arid;
            r_idx         <= ar_idx;
            r_len         <= s_axi_arlen;
            r_beat        <= '0;
            r_fixed       <= (s_axi_arburst == 2'b00);
            // The first rvalid lands exactly READ_LATENCY cycles after the AR handshake cycle.
            if (READ_LATENCY == 1) begin
              s_axi_rdata  <= mem[ar_idx];
              s_axi_rvalid <= !r_hold;
              s_axi_rlast  <= (s_axi_arlen == 8'd0);
              r_state      <= R_DATA;
            end else begin
              r_cnt   <= CNT_W'(READ_LATENCY - 2);
              r_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_cnt == '0) begin
            s_axi_rdata  <= mem[r_idx];
            s_axi_rvalid <= !r_hold;
            s_axi_rlast  <= (r_len == 8'd0);
            r_state      <= R_DATA;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        R_DATA: begin
          if (!s_axi_rvalid) begin
            s_axi_rvalid <= !r_hold;
          end else if (s_axi_rready) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_idx        <= r_idx_next;
              r_beat       <= r_beat + 8'd1;
              s_axi_rdata  <= mem[r_idx_next];
              s_axi_rvalid <= !r_hold;
              s_axi_rlast  <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
